mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din).
- Models 2^ADDR_W bytes of RAM plus the memory-mapped I/O window at mem_a[17:16]==2'b11.
- Drives the CPU's rdy_in through rdy_out, pausing the CPU on I/O back-pressure and after program stop.
- Sits between the cpu top and the board-level UART (rx/tx byte streams).

---
 rtl/mem_io_responder_pkg.sv | 17 +
 rtl/mem_io_responder_io_rx_fifo.sv | 42 ++++
 rtl/mem_io_responder.sv | 127 ++++++++++++
 tb/tb_mem_io_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared bus widths, I/O window offsets and responder state encoding.
package mem_io_responder_pkg;

    localparam int unsigned MEM_DATA_W  = 8;
    localparam int unsigned INST_ADDR_W = 32;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_RX_OFF   = 3'd0;
    localparam logic [2:0]  IO_STOP_OFF = 3'd4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STOP_TX = 2'd1,
        HALT    = 2'd2
    } state_e;

endpackage

// File: rtl/mem_io_responder_io_rx_fifo.sv
// Byte FIFO buffering UART input for the CPU's RX port; DEPTH must be a power of 2.
module io_rx_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [MEM_DATA_W-1:0] push_data,
    input  logic                  pop,
    output logic [MEM_DATA_W-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [MEM_DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM, UART RX/TX port and clock/stop port.
// Define CYCLE_COUNTER_EN to enable the cycle counter readable at 0x30004..0x30007.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INST_ADDR_W-1:0] mem_a,
    input  logic                   mem_wr,
    input  logic [MEM_DATA_W-1:0]  mem_dout,
    output logic [MEM_DATA_W-1:0]  mem_din,
    output logic                   rdy_out,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   halt
);
    state_e                state;
    logic                  io, rx_port, clk_port;
    logic                  rx_rd, rx_wr, stop_wr, pop, prev_rx_rd;
    logic                  fifo_full, fifo_empty;
    logic [MEM_DATA_W-1:0] fifo_head, clk_byte;
    logic [ADDR_W-1:0]     ram_idx;
    logic [MEM_DATA_W-1:0] ram [2**ADDR_W];
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^mem_a[INST_ADDR_W-1:18];

    assign io       = (mem_a[17:16] == IO_BASE[17:16]);
    assign rx_port  = io && (mem_a[2] == IO_RX_OFF[2]);
    assign clk_port = io && (mem_a[2] == IO_STOP_OFF[2]);
    assign ram_idx  = mem_a[ADDR_W-1:0];

    assign rx_rd   = rx_port && !mem_wr;
    assign rx_wr   = rx_port && mem_wr && (mem_dout != '0);
    assign stop_wr = clk_port && mem_wr;

    assign rdy_out = (state == RUN) && !(rx_rd && fifo_empty) &&
                     !(rx_wr && tx_valid && !tx_ready);

    // A held RX read address must pop only on its first accepted cycle.
    assign pop      = rx_rd && rdy_out && !prev_rx_rd;
    assign rx_ready = !fifo_full;

    io_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt, snap, clk_src;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt <= '0;
            snap      <= '0;
        end else begin
            if (state == RUN) cycle_cnt <= cycle_cnt + 1'b1;
            if (clk_port && !mem_wr && rdy_out && (mem_a[1:0] == 2'd0)) snap <= cycle_cnt;
        end
    end

    // Byte 0 is served live while the snapshot captures the same value.
    assign clk_src  = (mem_a[1:0] == 2'd0) ? cycle_cnt : snap;
    assign clk_byte = clk_src[{mem_a[1:0], 3'b000} +: 8];
`else
    assign clk_byte = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (rdy_out && mem_wr && !io) ram[ram_idx] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= RUN;
            mem_din    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            halt       <= 1'b0;
            prev_rx_rd <= 1'b0;
        end else begin
            prev_rx_rd <= rx_rd && rdy_out;

            if (!io)                     mem_din <= ram[ram_idx];
            else if (rx_rd)              begin if (pop) mem_din <= fifo_head; end
            else if (clk_port && !mem_wr) mem_din <= clk_byte;

            case (state)
                RUN: begin
                    if (rx_wr && rdy_out) begin
                        tx_data  <= mem_dout;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                    end
                    if (stop_wr) state <= STOP_TX;
                end
                STOP_TX: begin
                    if (!tx_valid || tx_ready) begin
                        tx_data  <= '0;
                        tx_valid <= 1'b1;
                        halt     <= 1'b1;
                        state    <= HALT;
                    end
                end
                HALT: begin
                    if (tx_ready) tx_valid <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised self-checking bench for mem_io_responder against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_io_responder;

    localparam logic [31:0] A_RX  = 32'h0003_0000;
    localparam logic [31:0] A_CLK = 32'h0003_0004;
    localparam logic [31:0] A_IDL = 32'h0000_0010;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    mem_io_responder #(.ADDR_W(17), .RX_DEPTH(16)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .rdy_out  (rdy_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt     (halt)
    );

    always #5 clk_in = ~clk_in;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    byte unsigned ram_m [int];
    byte unsigned rx_q [$];
    int unsigned  addrs [$];
    int unsigned  cnt_m;
    bit           run_m;
    bit           tv_m;
    byte unsigned td_m;

    logic [31:0]  a, snap_m;
    byte unsigned d, exp_b;
    bit           do_rd, do_push, push_ok, acc, hold, txr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advances one clock; the live cycle counter is modelled as RUN edges since reset.
    task automatic tick();
        if (rst_in) begin
            cnt_m = 0;
            run_m = 1'b1;
        end else if (run_m) begin
            cnt_m++;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
        mem_a    = addr;
        mem_wr   = wr;
        mem_dout = data;
    endtask

    task automatic do_reset();
        set_bus(A_IDL, 1'b0, 8'h00);
        rx_valid = 1'b0;
        rst_in   = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        rx_q.delete();
        tv_m = 1'b0;
    endtask

    task automatic ram_write(input logic [31:0] addr, input byte unsigned data);
        set_bus(addr, 1'b1, data);
        #1;
        check("ram_wr_rdy", rdy_out, 1);
        tick();
        ram_m[int'(addr & 32'h1FFFF)] = data;
    endtask

    task automatic ram_read(input logic [31:0] addr);
        set_bus(addr, 1'b0, 8'h00);
        #1;
        check("ram_rd_rdy", rdy_out, 1);
        tick();
        check("ram_rd", mem_din, ram_m[int'(addr & 32'h1FFFF)]);
    endtask

    task automatic rx_push(input byte unsigned data);
        rx_data  = data;
        rx_valid = 1'b1;
        #1;
        push_ok = (rx_q.size() < 16);
        check("rx_ready", rx_ready, push_ok);
        tick();
        if (push_ok) rx_q.push_back(data);
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b0;
        tx_ready = 1'b1;
        rx_data  = 8'h00;
        do_reset();

        check("rst_mem_din", mem_din, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_halt", halt, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_rdy", rdy_out, 1);

        // RAM: directed, aliasing and randomised read-after-write
        ram_write(32'h0000_0010, 8'hA5);
        ram_read(32'h0000_0010);
        ram_read(32'h0002_0010);
        ram_read(32'hFFFC_0010);
        addrs.push_back(32'h10);
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 32'h2FFFF) | ($urandom << 18);
            d = 8'($urandom);
            ram_write(a, d);
            addrs.push_back(a);
            if ($urandom_range(0, 1) == 0) ram_read(a);
            else ram_read(addrs[$urandom_range(0, addrs.size() - 1)]);
        end

        // RX: held read pops once, empty read stalls until a push
        set_bus(A_IDL, 1'b0, 8'h00);
        rx_push(8'h41);
        rx_push(8'h42);
        set_bus(A_RX, 1'b0, 8'h00);
        #1;
        check("rx_rd_rdy", rdy_out, 1);
        exp_b = rx_q.pop_front();
        tick();
        check("rx_first", mem_din, exp_b);
        tick();
        tick();
        check("rx_hold", mem_din, exp_b);
        set_bus(A_IDL, 1'b0, 8'h00);
        tick();
        set_bus(A_RX, 1'b0, 8'h00);
        exp_b = rx_q.pop_front();
        tick();
        check("rx_second", mem_din, exp_b);
        set_bus(A_IDL, 1'b0, 8'h00);
        tick();
        set_bus(A_RX, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rx_empty_stall", rdy_out, 0);
            tick();
        end
        rx_data  = 8'h43;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        #1;
        check("rx_unstall", rdy_out, 1);
        tick();
        check("rx_after_stall", mem_din, 8'h43);
        set_bus(A_IDL, 1'b0, 8'h00);
        tick();

        // RX: fill to full, overflow attempt, then random push/pop
        for (int i = 0; i < 16; i++) rx_push(8'($urandom));
        check("rx_full", rx_ready, 0);
        rx_push(8'hEE);
        for (int i = 0; i < 80; i++) begin
            do_rd   = (i % 2 == 0) && (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
            do_push = 1'($urandom_range(0, 1));
            d       = 8'($urandom);
            if (do_rd) set_bus(A_RX, 1'b0, 8'h00);
            else set_bus(A_IDL, 1'b0, 8'h00);
            rx_valid = do_push;
            rx_data  = d;
            #1;
            push_ok = do_push && (rx_q.size() < 16);
            check("rx_rand_ready", rx_ready, rx_q.size() < 16);
            check("rx_rand_rdy", rdy_out, 1);
            if (do_rd) exp_b = rx_q.pop_front();
            if (push_ok) rx_q.push_back(d);
            tick();
            if (do_rd) check("rx_rand_pop", mem_din, exp_b);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 17 && rx_q.size() > 0; i++) begin
            set_bus(A_RX, 1'b0, 8'h00);
            exp_b = rx_q.pop_front();
            tick();
            check("rx_drain", mem_din, exp_b);
            set_bus(A_IDL, 1'b0, 8'h00);
            tick();
        end

        // TX: directed back-pressure
        tx_ready = 1'b0;
        set_bus(A_RX, 1'b1, 8'h31);
        #1;
        check("tx_w1_rdy", rdy_out, 1);
        tick();
        check("tx_w1_valid", tx_valid, 1);
        check("tx_w1_data", tx_data, 8'h31);
        set_bus(A_RX, 1'b1, 8'h32);
        #1;
        check("tx_w2_stall", rdy_out, 0);
        tick();
        check("tx_w2_held", tx_data, 8'h31);
        tx_ready = 1'b1;
        #1;
        check("tx_w2_rdy", rdy_out, 1);
        tick();
        check("tx_w2_valid", tx_valid, 1);
        check("tx_w2_data", tx_data, 8'h32);
        set_bus(A_IDL, 1'b0, 8'h00);
        tick();
        check("tx_clear", tx_valid, 0);
        set_bus(A_RX, 1'b1, 8'h00);
        tick();
        check("tx_zero", tx_valid, 0);

        // TX: random data (including zero) against random tx_ready
        tv_m = 1'b0;
        td_m = 8'h00;
        hold = 1'b0;
        d    = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if (!hold) d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            txr = 1'($urandom_range(0, 1));
            set_bus(A_RX, 1'b1, d);
            tx_ready = txr;
            #1;
            acc = !((d != 0) && tv_m && !txr);
            check("tx_rand_rdy", rdy_out, acc);
            if (acc && d != 0) begin
                tv_m = 1'b1;
                td_m = d;
            end else if (txr) begin
                tv_m = 1'b0;
            end
            tick();
            check("tx_rand_valid", tx_valid, tv_m);
            if (tv_m) check("tx_rand_data", tx_data, td_m);
            hold = !acc;
        end
        tx_ready = 1'b1;
        set_bus(A_IDL, 1'b0, 8'h00);
        tick();

        // Clock: snapshot consistency across the four byte reads
        do_reset();
        for (int i = 0; i < 100; i++) tick();
        for (int rep = 0; rep < 2; rep++) begin
            set_bus(A_CLK, 1'b0, 8'h00);
            snap_m = cnt_m;
`ifndef CYCLE_COUNTER_EN
            snap_m = '0;
`endif
            tick();
            check("clk_b0", mem_din, snap_m[7:0]);
            for (int b = 1; b < 4; b++) begin
                set_bus(A_IDL, 1'b0, 8'h00);
                for (int g = $urandom_range(0, 5); g > 0; g--) tick();
                set_bus(A_CLK + 32'(b), 1'b0, 8'h00);
                tick();
                check("clk_bn", mem_din, snap_m[8*b +: 8]);
            end
            set_bus(A_IDL, 1'b0, 8'h00);
            for (int g = $urandom_range(1, 20); g > 0; g--) tick();
        end

        // Reset during STOP_TX with three bytes queued
        ram_write(32'h0000_1234, 8'h5A);
        set_bus(A_IDL, 1'b0, 8'h00);
        rx_push(8'h01);
        rx_push(8'h02);
        rx_push(8'h03);
        tx_ready = 1'b0;
        set_bus(A_RX, 1'b1, 8'h31);
        tick();
        set_bus(A_CLK, 1'b1, 8'hFF);
        #1;
        check("stop_rdy", rdy_out, 1);
        tick();
        run_m = 1'b0;
        set_bus(A_IDL, 1'b0, 8'h00);
        #1;
        check("stoptx_rdy", rdy_out, 0);
        tick();
        tick();
        check("stoptx_halt", halt, 0);
        check("stoptx_blocked", tx_data, 8'h31);
        do_reset();
        check("rst2_halt", halt, 0);
        check("rst2_tx_valid", tx_valid, 0);
        check("rst2_rx_ready", rx_ready, 1);
        set_bus(A_RX, 1'b0, 8'h00);
        #1;
        check("rst2_fifo_empty", rdy_out, 0);
        set_bus(A_IDL, 1'b0, 8'h00);
        ram_read(32'h0000_1234);

        // Stop: '\0' sent then permanent halt
        tx_ready = 1'b1;
        set_bus(A_CLK, 1'b1, 8'h00);
        #1;
        check("stop2_rdy", rdy_out, 1);
        tick();
        run_m = 1'b0;
        set_bus(A_IDL, 1'b0, 8'h00);
        #1;
        check("stop2_pause", rdy_out, 0);
        check("stop2_no_tx_yet", tx_valid, 0);
        tick();
        check("stop2_tx_valid", tx_valid, 1);
        check("stop2_tx_nul", tx_data, 8'h00);
        check("stop2_halt", halt, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_hold", halt, 1);
            check("halt_rdy", rdy_out, 0);
            check("halt_tx_clear", tx_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
